// File: rtl/coord_stack.sv
// LIFO of (x,y) coordinate pairs with a registered pop port
// and a one-cycle fail pulse on illegal requests.
module coord_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             xIn,
  input  logic [W-1:0]             yIn,
  output logic [W-1:0]             xOut,
  output logic [W-1:0]             yOut,
  output logic                     empty,
  output logic                     full,
  output logic                     fail,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2*W-1:0] mem [DEPTH];
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  top;
  logic           wr_only;
  logic           rd_only;
  logic           swap;
  logic           bad;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // count==DEPTH aliases ptr to 0, so top still lands on DEPTH-1
  assign ptr   = count[PW-1:0];
  assign top   = ptr - 1'b1;

  always_comb begin
    wr_only = push && !pop && !full;
    rd_only = pop && !push && !empty;
    swap    = push && pop;
    bad     = (push && !pop && full) ||
              (pop && !push && empty);
  end

  always_ff @(posedge clk) begin
    if (wr_only)
      mem[ptr] <= {xIn, yIn};
    else if (swap && !empty)
      mem[top] <= {xIn, yIn};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      xOut  <= '0;
      yOut  <= '0;
      fail  <= 1'b0;
    end else begin
      fail <= bad;
      unique case (1'b1)
        wr_only: count <= count + 1'b1;
        rd_only: begin
          {xOut, yOut} <= mem[top];
          count        <= count - 1'b1;
        end
        swap: begin
          if (empty)
            {xOut, yOut} <= {xIn, yIn};
          else
            {xOut, yOut} <= mem[top];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coord_stack.sv
// Scoreboard bench for coord_stack: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_coord_stack;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [3:0] xIn;
  logic [3:0] yIn;
  logic [3:0] xOut;
  logic [3:0] yOut;
  logic       empty;
  logic       full;
  logic       fail;
  logic [4:0] count;

  int checks;
  int failures;

  typedef struct {
    string      name;
    logic [3:0] x;
    logic [3:0] y;
    int         cnt;
    logic       fl;
  } exp_t;

  exp_t q[$];

  coord_stack #(.W(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .xIn(xIn), .yIn(yIn), .xOut(xOut), .yOut(yOut),
    .empty(empty), .full(full), .fail(fail), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor
  initial begin
    exp_t e;
    logic ee;
    logic ef;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e  = q.pop_front();
        ee = (e.cnt == 0);
        ef = (e.cnt == 16);
        checks++;
        if (xOut !== e.x || yOut !== e.y ||
            int'(count) != e.cnt || empty !== ee ||
            full !== ef || fail !== e.fl) begin
          failures++;
          $display("FAIL %s: got x=%0d y=%0d cnt=%0d e=%0b f=%0b fail=%0b want x=%0d y=%0d cnt=%0d e=%0b f=%0b fail=%0b",
                   e.name, xOut, yOut, count, empty, full, fail,
                   e.x, e.y, e.cnt, ee, ef, e.fl);
        end
      end
    end
  end

  task automatic expect_now(input string n, input int x,
                            input int y, input int c,
                            input logic f);
    exp_t e;
    e.name = n;
    e.x    = 4'(x);
    e.y    = 4'(y);
    e.cnt  = c;
    e.fl   = f;
    q.push_back(e);
  endtask

  task automatic step(input logic p, input logic r,
                      input int xi, input int yi,
                      input string n, input int x,
                      input int y, input int c,
                      input logic f);
    @(negedge clk);
    push = p;
    pop  = r;
    xIn  = 4'(xi);
    yIn  = 4'(yi);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    expect_now(n, x, y, c, f);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    xIn  = '0;
    yIn  = '0;
    #3;
    expect_now("reset", 0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    step(1, 0, 3, 5,  "push1", 0, 0, 1, 0);
    step(1, 0, 7, 1,  "push2", 0, 0, 2, 0);
    step(1, 0, 15, 0, "push3", 0, 0, 3, 0);
    step(0, 1, 0, 0,  "pop1", 15, 0, 2, 0);
    step(0, 1, 0, 0,  "pop2", 7, 1, 1, 0);
    step(0, 1, 0, 0,  "pop3", 3, 5, 0, 0);
    step(0, 1, 0, 0,  "pop_empty", 3, 5, 0, 1);
    step(0, 0, 0, 0,  "fail_clear", 3, 5, 0, 0);
    step(0, 1, 0, 0,  "b2b_fail1", 3, 5, 0, 1);
    step(0, 1, 0, 0,  "b2b_fail2", 3, 5, 0, 1);
    step(0, 0, 0, 0,  "b2b_clear", 3, 5, 0, 0);

    for (int i = 0; i < 16; i++)
      step(1, 0, i, 15 - i, "fill", 3, 5, i + 1, 0);
    step(1, 0, 9, 9, "push_full", 3, 5, 16, 1);
    step(0, 0, 0, 0, "full_idle", 3, 5, 16, 0);
    for (int j = 0; j < 16; j++)
      step(0, 1, 0, 0, "drain", 15 - j, j, 15 - j, 0);

    step(1, 0, 9, 8, "sw_push1", 0, 15, 1, 0);
    step(1, 0, 4, 4, "sw_push2", 0, 15, 2, 0);
    step(1, 1, 6, 6, "swap", 4, 4, 2, 0);
    step(0, 1, 0, 0, "swap_pop1", 6, 6, 1, 0);
    step(0, 1, 0, 0, "swap_pop2", 9, 8, 0, 0);
    step(1, 1, 2, 3, "pass_thru", 2, 3, 0, 0);

    for (int k = 0; k < 5; k++)
      step(1, 0, k, k, "pre_rst", 2, 3, k + 1, 0);
    @(posedge clk);
    #2;
    rst  = 1'b0;
    push = 1'b1;
    xIn  = 4'd9;
    yIn  = 4'd9;
    #1;
    expect_now("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    expect_now("rst_discard", 0, 0, 0, 0);
    @(negedge clk);
    push = 1'b0;
    rst  = 1'b1;
    step(1, 0, 5, 6, "post_rst_push", 0, 0, 1, 0);
    step(0, 1, 0, 0, "post_rst_pop", 5, 6, 0, 0);

    repeat (4) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coord_stack.md
COORD_STACK -- requirements
Module: coord_stack

Interface
REQ-001 Parameter W, default 4, width of each coordinate field.
REQ-002 Parameter DEPTH, default 16, number of (x,y) entries; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port push  input  1  write request: store (xIn,yIn) on top.
REQ-006 Port pop  input  1  read request: remove top entry and present it on (xOut,yOut).
REQ-007 Port xIn  input  W  x coordinate to push.
REQ-008 Port yIn  input  W  y coordinate to push.
REQ-009 Port xOut  output  W  registered x of the last popped entry.
REQ-010 Port yOut  output  W  registered y of the last popped entry.
REQ-011 Port empty  output  1  high when count equals 0.
REQ-012 Port full  output  1  high when count equals DEPTH.
REQ-013 Port fail  output  1  registered one-cycle pulse flagging an illegal request.
REQ-014 Port count  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-015 Storage SHALL be LIFO: DEPTH entries of 2*W bits, plus a stack pointer equal to count.
REQ-016 empty and full SHALL be combinational decodes of count, valid in the same cycle.
REQ-017 Push only, not full: entry[count] <= {xIn,yIn}; count +1; xOut/yOut hold; fail 0.
REQ-018 Pop only, not empty: {xOut,yOut} <= entry[count-1]; count -1; popped data visible the cycle after the edge (latency 1).
REQ-019 Push and pop together, not empty: {xOut,yOut} <= current top; top entry <= {xIn,yIn}; count unchanged; fail 0.
REQ-020 Push and pop together, empty: {xOut,yOut} <= {xIn,yIn} (pass-through); count stays 0; fail 0.
REQ-021 Push only while full: storage, count and xOut/yOut unchanged; fail = 1 for exactly the next cycle.
REQ-022 Pop only while empty: storage, count and xOut/yOut unchanged; fail = 1 for exactly the next cycle.
REQ-023 Neither push nor pop: all state held; fail 0.
REQ-024 fail SHALL deassert on the first edge without an illegal request; back-to-back illegal requests SHALL hold fail high continuously.
REQ-025 count SHALL never exceed DEPTH or wrap below 0; pointer arithmetic SHALL not wrap.
REQ-026 X or Z on xIn/yIn SHALL be tolerated when push is low.

Reset
REQ-027 rst low SHALL immediately, without waiting for clk, force count=0, xOut=0, yOut=0, fail=0, giving empty=1 and full=0.
REQ-028 Storage contents need not be cleared; no behaviour SHALL depend on them after reset.
REQ-029 Reset asserted mid-operation SHALL discard any push/pop in that cycle; the first edge after rst returns high SHALL process requests normally.

Verification
REQ-030 Reset, then push (3,5), (7,1), (15,0) on three edges -> count=3, empty=0, fail=0.
REQ-031 Pop three times -> xOut/yOut read (15,0), (7,1), (3,5) on successive cycles; count=0, empty=1.
REQ-032 Pop while empty -> fail high for one cycle; count stays 0; xOut/yOut keep (3,5).
REQ-033 Push 16 entries (i,15-i), i=0..15 -> full=1; 17th push (9,9) -> fail pulse, count=16; then 16 pops return (15,0) down to (0,15).
REQ-034 With count=2, top (4,4), assert push (6,6) and pop together -> xOut/yOut=(4,4), count=2; next pop returns (6,6). On empty, push and pop together with (2,3) -> xOut/yOut=(2,3), count=0, fail=0.
REQ-035 Drive rst low between clock edges with count=5 -> count=0, empty=1, fail=0 before the next edge; a push after release gives count=1.
